// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO and stalls the pipeline while busy
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod;
  logic [WIDTH-1:0] opd, abs_a, abs_b, quo, rem;
  logic [WIDTH:0] msum, dcand, ddiff;
  logic is_div, neg_q, neg_r, div0, sa, sb, go;
  assign busy = state != IDLE;
  assign go = start & ~flush & (state == IDLE);
  assign sa = ~op[0] & a[WIDTH-1];
  assign sb = ~op[0] & b[WIDTH-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;
  always_comb begin
    state_n = flush ? IDLE
            : state == IDLE ? (start ? CALC : IDLE)
            : state == CALC ? (cnt == '0 ? FIX : CALC)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    dcand = acc[2*WIDTH-1:WIDTH-1];
    ddiff = dcand - {1'b0, opd};
    acc_step = !is_div ? {msum, acc[WIDTH-1:1]}
             : ddiff[WIDTH] ? {dcand[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
             : {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod = neg_q ? -acc : acc;
    quo = div0 ? '1 : neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  // a zero divisor leaves the remainder equal to |a|, so the dividend-sign fixup restores a
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      opd <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0 <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && hi_we) hi <= wdata;
      if (state == IDLE && lo_we) lo <= wdata;
      if (go) begin
        is_div <= op[1];
        neg_q <= sa ^ sb;
        neg_r <= op[1] & sa;
        div0 <= op[1] & (b == '0);
        acc <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
        opd <= op[1] ? abs_b : abs_a;
        cnt <= CW'(WIDTH - 1);
      end else if (state == CALC && !flush) begin
        acc <= acc_step;
        cnt <= cnt - CW'(1);
      end else if (state == FIX && !flush) begin
        hi <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
        lo <= is_div ? quo : prod[WIDTH-1:0];
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter; expected HI/LO come from native SV arithmetic
module tb_mdu_iter;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = 2'd0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  logic [63:0] sb[$];
  int n_checks = 0, n_fail = 0;
  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] p;
    case (o)
      2'd0: begin
        p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return p;
      end
      2'd1: return {32'b0, x} * {32'b0, y};
      2'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {$signed(x) % $signed(y), $signed(x) / $signed(y)};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) check("spurious_done", 64'd1, 64'd0);
      else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("hi", {32'b0, hi}, {32'b0, e[63:32]});
        check("lo", {32'b0, lo}, {32'b0, e[31:0]});
        check("busy_with_done", {63'b0, busy}, 64'd0);
      end
    end
  end
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    if (push) sb.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask
  task automatic finish_op(input int exp_n);
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(n), 64'(exp_n));
    check("done_rise", {63'b0, done}, 64'd1);
    @(negedge clk);
    check("done_pulse", {63'b0, done}, 64'd0);
  endtask
  initial begin
    logic [31:0] hold;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    launch(2'd0, 32'hFFFF_FFFF, 32'h2, 1); finish_op(33);
    launch(2'd1, 32'hFFFF_FFFF, 32'h2, 1); finish_op(33);
    launch(2'd2, 32'hFFFF_FFF9, 32'h2, 1); finish_op(33);
    launch(2'd3, 32'h7, 32'h0, 1); finish_op(33);
    launch(2'd2, 32'hFFFF_FFF9, 32'h0, 1); finish_op(33);
    launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1); finish_op(33);
    launch(2'd0, 32'h8000_0000, 32'h8000_0000, 1); finish_op(33);
    launch(2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 1); finish_op(33);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = (i % 2 == 0) ? $urandom : $urandom_range(1, 300);
      launch(2'(i % 4), x, y, 1);
      finish_op(33);
    end
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mthi", {32'b0, hi}, 64'h1234);
    check("mtlo", {32'b0, lo}, 64'h5678);
    launch(2'd3, 32'd100, 32'd7, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'd0);
    check("flush_done", {63'b0, done}, 64'd0);
    check("flush_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
    repeat (40) @(negedge clk);
    check("flush_hold", {hi, lo}, 64'h0000_1234_0000_5678);
    launch(2'd3, 32'd100, 32'd7, 1);
    hold = hi;
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    check("busy_mthi_ignored", {32'b0, hi}, {32'b0, hold});
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    finish_op(30);
    repeat (40) @(negedge clk);
    launch(2'd1, 32'hDEAD_0001, 32'h1234_5678, 0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    launch(2'd1, 32'd3, 32'd5, 1);
    finish_op(33);
    check("mult_3x5", {hi, lo}, 64'd15);
    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
